// File: rtl/fifo_reader_pkg.sv
// Shared types for the FIFO burst reader: the two-state drain FSM encoding.
package fifo_reader_pkg;

  // IDLE waits for enough data (or a timeout); SEND streams one burst.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_burst_reader.sv
// Drains the read port of a FIFO in bursts of up to BURST words and presents
// them as a framed valid/ready stream (sop/eop/len). A partial burst is
// flushed once the FIFO has held data for TIMEOUT idle cycles.
module fifo_burst_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int WIDTHU  = 4,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 15,
  parameter int LW      = $clog2(BURST + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [WIDTHU-1:0] fifo_rdused,
  input  logic [WIDTH-1:0]  fifo_q,
  output logic              fifo_rden,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [LW-1:0]     out_len,
  output logic              busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [WIDTHU-1:0] BURST_U   = WIDTHU'(BURST);
  localparam logic [LW-1:0]     BURST_L   = LW'(BURST);
  localparam logic [TW-1:0]     TIMEOUT_T = TW'(TIMEOUT);
  localparam logic [LW-1:0]     ONE_L     = LW'(1);

  // Parameter sanity: a burst must fit in the usable FIFO depth, and the
  // timeout must be reachable.
  generate
    if (BURST < 1 || BURST > (1 << (WIDTHU - 1))) begin : g_bad_burst
      $error("fifo_burst_reader: BURST must be in 1..2**(WIDTHU-1)");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("fifo_burst_reader: TIMEOUT must be at least 1");
    end
  endgenerate

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [LW-1:0]   len_reg, len_next;
  logic [LW-1:0]   remaining_reg, remaining_next;
  logic            first_reg, first_next;

  logic            fifo_nonempty;
  logic            fifo_has_burst;
  logic            timer_expired;
  logic            start_burst;
  logic            sending;
  logic            handshake;
  logic            last_word;
  logic [LW-1:0]   start_len;

  // Start conditions and burst length derived from the current fill level.
  always_comb begin
    fifo_nonempty  = (fifo_rdused != '0);
    fifo_has_burst = (fifo_rdused >= BURST_U);
    timer_expired  = (timer_reg == TIMEOUT_T);
    start_burst    = enable && (fifo_has_burst || (fifo_nonempty && timer_expired));
    // Below BURST the fill level fits in LW bits, so the truncation is exact.
    start_len      = fifo_has_burst ? BURST_L : LW'(fifo_rdused);
    sending        = (state_reg == ST_SEND);
    handshake      = sending && out_ready;
    last_word      = (remaining_reg == ONE_L);
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a started burst always runs to its last handshake.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_burst) begin
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (handshake && last_word) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Next values for the idle timer and the burst bookkeeping counters.
  always_comb begin
    timer_next     = timer_reg;
    len_next       = len_reg;
    remaining_next = remaining_reg;
    first_next     = first_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_burst) begin
          timer_next     = '0;
          len_next       = start_len;
          remaining_next = start_len;
          first_next     = 1'b1;
        end else if (!fifo_nonempty || fifo_has_burst) begin
          // Only a partial fill ages; empty or full-burst levels reset it.
          timer_next = '0;
        end else if (!timer_expired) begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_SEND: begin
        timer_next = '0;
        if (handshake) begin
          remaining_next = remaining_reg - ONE_L;
          first_next     = 1'b0;
        end
      end
      default: begin
        timer_next = '0;
      end
    endcase
  end

  // Datapath registers: timer, latched length, words left, first-word flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_reg     <= '0;
      len_reg       <= '0;
      remaining_reg <= '0;
      first_reg     <= 1'b0;
    end else begin
      timer_reg     <= timer_next;
      len_reg       <= len_next;
      remaining_reg <= remaining_next;
      first_reg     <= first_next;
    end
  end

  // Stream outputs: data passes straight through from the FIFO head, and
  // the pop is the handshake itself so the FIFO advances in lockstep.
  always_comb begin
    out_data  = fifo_q;
    out_valid = sending;
    out_sop   = sending && first_reg;
    out_eop   = sending && last_word;
    out_len   = sending ? len_reg : '0;
    busy      = sending;
    fifo_rden = handshake;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Single-clock drain engine for the read port of `dc_fifo`. It watches the FIFO fill level, pulls words in bursts of up to `BURST`, and presents them on a framed valid/ready stream with start/end markers and a length field. A partial burst is flushed after a programmable idle timeout. It sits in the FIFO's read-clock domain, in front of packet consumers such as DMA or bus-master blocks.

## Interface
Parameters:
- `WIDTH`, 16: data word width; must match the FIFO.
- `WIDTHU`, 4: FIFO used-count width. Usable FIFO depth is 2^(WIDTHU-1).
- `BURST`, 4: maximum words per burst. Must satisfy 1 ≤ `BURST` ≤ 2^(WIDTHU-1).
- `TIMEOUT`, 15: idle cycles before a partial burst is flushed. Must be ≥ 1.
- `LW`, `$clog2(BURST+1)`: width of the length field (derived).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  the single clock; the FIFO read clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `enable`  in  1  allows new bursts to start.
- `fifo_rdused`  in  WIDTHU  FIFO word count.
- `fifo_q`  in  WIDTH  FIFO head word; valid whenever `fifo_rdused` ≠ 0.
- `fifo_rden`  out  1  pop request to the FIFO.
- `out_data`  out  WIDTH  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.
- `out_sop`  out  1  marks the first word of a burst.
- `out_eop`  out  1  marks the last word of a burst.
- `out_len`  out  LW  burst length; meaningful while `out_valid` is high.
- `busy`  out  1  high while in the SEND state.

## Operation
- FIFO contract:
  - `fifo_q` always shows the head word.
  - Asserting `fifo_rden` while `fifo_rdused` ≠ 0 pops the head.
  - The next word appears on `fifo_q` the following cycle.
  - `fifo_rdused` already accounts for the pop on the following cycle.
- The state machine has two states, IDLE and SEND.
- IDLE → SEND when `enable` is high and either:
  - `fifo_rdused` ≥ `BURST`, or
  - `fifo_rdused` ≠ 0 and `timer` == `TIMEOUT`.
- On entering SEND:
  - latch `len` = min(`fifo_rdused`, `BURST`);
  - set `remaining` = `len`, `first` = 1, `timer` = 0.
- In SEND:
  - `out_valid` = 1 and `out_data` = `fifo_q`.
  - `out_sop` = `first`.
  - `out_eop` = (`remaining` == 1).
  - `out_len` = `len`.
- A handshake (`out_valid` & `out_ready`) does the following:
  - drives `fifo_rden` = 1 combinationally;
  - decrements `remaining` and clears `first`;
  - when the handshake occurs with `remaining` == 1, the next state is IDLE.
- `fifo_rden` is never asserted outside a handshake. Data availability is guaranteed because `len` ≤ `fifo_rdused` at burst start and this block is the FIFO's only reader.
- `timer` (width `$clog2(TIMEOUT+1)`) behaviour in IDLE:
  - increments while 0 < `fifo_rdused` < `BURST`;
  - saturates at `TIMEOUT`;
  - clears when `fifo_rdused` == 0, `fifo_rdused` ≥ `BURST`, or SEND is entered.
- `enable` low:
  - suppresses burst starts only;
  - a burst already in SEND always completes;
  - the timer keeps counting and saturating.

## Timing
- Reset values: `out_valid`, `out_sop`, `out_eop`, `busy`, `fifo_rden` = 0; `out_len` = 0; `out_data` = `fifo_q` (pass-through); state = IDLE; `timer` = 0.
- Latency: if the start condition is true at the edge ending cycle N, `out_valid` rises in cycle N+1.
- The output path is combinational (`fifo_q` is already registered inside the FIFO). `fifo_rden` depends combinationally on `out_ready`.
- With `out_ready` held high, a burst streams at one word per cycle.
- At least one IDLE cycle separates consecutive bursts. With data continuously available, throughput is BURST/(BURST+1).
- `out_data`, `out_sop`, `out_eop` and `out_len` hold stable while `out_valid` & !`out_ready`.
- Reset mid-burst: outputs drop asynchronously, and the rest of the burst is abandoned. FIFO contents are outside this block's control.

## Structure
- Package `fifo_reader_pkg` holds the state enum (`ST_IDLE`, `ST_SEND`).
- No sub-module is used. The timer and length counter are small enough to stay inline.
- Elaboration-time assertions check the `BURST` and `TIMEOUT` parameter limits.

## Test plan
The bench instantiates `dc_fifo` (WIDTH=16, WIDTHU=4) with `wrclk` = `rdclk` = `clk` as the source, using `BURST`=4 and `TIMEOUT`=15.
- Reset: `resetn` low → all outputs 0, no `fifo_rden`; release with an empty FIFO → outputs stay 0.
- Full burst plus flush, `out_ready`=1:
  - write 0xA0–0xA4 → burst of 0xA0–0xA3 with `out_len`=4, sop on 0xA0, eop on 0xA3;
  - then 0xA4 is sent after 15 idle cycles with `out_len`=1 and sop=eop=1.
- Backpressure: `out_ready` pattern 1,0,1,0,… over 4 words → each word held while not ready; exactly 4 `fifo_rden` pulses; order preserved.
- Timeout race:
  - 2 words with no more writes → burst with `out_len`=2 starts 1 cycle after `timer` reaches 15;
  - repeat, but write 2 more words at timer=8 → burst with `out_len`=4 once `fifo_rdused` reaches 4.
- Enable:
  - `enable`=0 with 8 words queued → no `fifo_rden` for 50 cycles;
  - drop `enable` after the 2nd word of a burst → burst still ends with eop on word 4, and no new burst starts.
- Reset mid-burst: `resetn` pulsed after word 2 → `out_valid`=0 immediately, state IDLE, `timer`=0; normal bursting resumes after FIFO refill.
